p1v_reset_seq: RTL

// Parametrised reset sequencer for the P1V top level. Takes over the job of the

---
 rtl/p1v_reset_seq_if.sv | 24 ++
 rtl/p1v_reset_seq.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/p1v_reset_seq_if.sv
// Control/status bundle between the P1V reset sequencer and its controller.
// master drives the requests and observes the resets; slave is the sequencer.
interface p1v_reset_seq_if #(
    parameter int unsigned N_OUT = 4,
    parameter int unsigned WDT_W = 24
);
    logic             sw_reset;
    logic             wdt_en;
    logic             wdt_kick;
    logic [WDT_W-1:0] wdt_limit;
    logic [N_OUT-1:0] nres_out;
    logic             busy;
    logic [1:0]       reset_cause;

    modport master (
        output sw_reset, wdt_en, wdt_kick, wdt_limit,
        input  nres_out, busy, reset_cause
    );

    modport slave (
        input  sw_reset, wdt_en, wdt_kick, wdt_limit,
        output nres_out, busy, reset_cause
    );
endinterface

// File: rtl/p1v_reset_seq.sv
// P1V reset sequencer: stretches the pin reset, adds software and watchdog reset
// sources, and releases N_OUT active-low resets in staggered order.
module p1v_reset_seq #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 24,
    parameter int unsigned HOLD_CYCLES = 1000000,
    parameter int unsigned N_OUT       = 4,
    parameter int unsigned STAGGER     = 16,
    parameter int unsigned WDT_W       = 24
) (
    input  logic           clk_cog,
    input  logic           inp_resn,
    p1v_reset_seq_if.slave rs
);

    localparam int unsigned LAST_REL = STAGGER * (N_OUT - 1);
    localparam int unsigned CNT_NEED = (HOLD_CYCLES > LAST_REL) ? HOLD_CYCLES : LAST_REL;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(LAST_REL);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [WDT_W-1:0] WDT_ONE   = WDT_W'(1);

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("p1v_reset_seq: SYNC_STAGES must be at least 2");
        end
        if (HOLD_CYCLES < 1) begin : g_bad_hold
            $error("p1v_reset_seq: HOLD_CYCLES must be at least 1");
        end
        if (STAGGER < 1) begin : g_bad_stagger
            $error("p1v_reset_seq: STAGGER must be at least 1");
        end
        if (N_OUT < 1 || N_OUT > 8) begin : g_bad_nout
            $error("p1v_reset_seq: N_OUT must be in 1..8");
        end
        if (64'(CNT_NEED) >= (64'd1 << CNT_W)) begin : g_bad_cntw
            $error("p1v_reset_seq: CNT_W too narrow for HOLD_CYCLES / stagger span");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_HOLD,
        S_RELEASE,
        S_RUN
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_PIN = 2'b00,
        CAUSE_SW  = 2'b01,
        CAUSE_WDT = 2'b10
    } cause_t;

    state_t             state;
    cause_t             cause_q;
    logic [CNT_W-1:0]   cnt;
    logic [WDT_W-1:0]   wdt_cnt;
    logic [N_OUT-1:0]   nres_q;
    logic               busy_q;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rst_ok;

    logic [CNT_W-1:0]   cnt_inc;
    logic [N_OUT-1:0]   rel_mask;
    logic               wdt_active;
    logic               wdt_fire;

    // rst_ok sits one flop past the chain so it rises SYNC_STAGES clocks after
    // the first edge that sees inp_resn high.
    always_ff @(posedge clk_cog or negedge inp_resn) begin
        if (!inp_resn) begin
            sync_q <= '0;
            rst_ok <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
            rst_ok <= sync_q[SYNC_STAGES-1];
        end
    end

    always_comb begin
        cnt_inc  = cnt + CNT_ONE;
        rel_mask = '0;
        for (int unsigned i = 0; i < N_OUT; i++) begin
            rel_mask[i] = (cnt_inc == CNT_W'(STAGGER * i));
        end
    end

    // Comparing with >= lets a lowered wdt_limit fire at once instead of being
    // skipped past by a count that already exceeds it.
    always_comb begin
        wdt_active = (state == S_RUN) && rs.wdt_en && (rs.wdt_limit != '0);
        wdt_fire   = wdt_active && !rs.wdt_kick && (wdt_cnt >= (rs.wdt_limit - WDT_ONE));
    end

    always_ff @(posedge clk_cog or negedge inp_resn) begin
        if (!inp_resn) begin
            state   <= S_HOLD;
            cause_q <= CAUSE_PIN;
            cnt     <= '0;
            wdt_cnt <= '0;
            nres_q  <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state)
                S_HOLD: begin
                    wdt_cnt <= '0;
                    if (!rst_ok || rs.sw_reset) begin
                        cnt <= '0;
                    end else if (cnt == HOLD_LAST) begin
                        cnt <= '0;
                        if (N_OUT == 1) begin
                            nres_q <= '1;
                            busy_q <= 1'b0;
                            state  <= S_RUN;
                        end else begin
                            nres_q <= N_OUT'(1);
                            state  <= S_RELEASE;
                        end
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                S_RELEASE: begin
                    wdt_cnt <= '0;
                    if (rs.sw_reset) begin
                        state   <= S_HOLD;
                        cause_q <= CAUSE_SW;
                        cnt     <= '0;
                        nres_q  <= '0;
                        busy_q  <= 1'b1;
                    end else begin
                        cnt    <= cnt_inc;
                        nres_q <= nres_q | rel_mask;
                        if (cnt_inc == REL_LAST) begin
                            busy_q <= 1'b0;
                            state  <= S_RUN;
                        end
                    end
                end

                S_RUN: begin
                    if (rs.sw_reset || wdt_fire) begin
                        state   <= S_HOLD;
                        cause_q <= rs.sw_reset ? CAUSE_SW : CAUSE_WDT;
                        cnt     <= '0;
                        wdt_cnt <= '0;
                        nres_q  <= '0;
                        busy_q  <= 1'b1;
                    end else begin
                        nres_q <= '1;
                        busy_q <= 1'b0;
                        if (!wdt_active || rs.wdt_kick) begin
                            wdt_cnt <= '0;
                        end else if (wdt_cnt != '1) begin
                            wdt_cnt <= wdt_cnt + WDT_ONE;
                        end
                    end
                end

                default: begin
                    state   <= S_HOLD;
                    cnt     <= '0;
                    wdt_cnt <= '0;
                    nres_q  <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign rs.nres_out    = nres_q;
    assign rs.busy        = busy_q;
    assign rs.reset_cause = cause_q;

endmodule
